hpdcache_req_tracker: RTL

HPDCACHE_REQ_TRACKER -- requirements
Module: hpdcache_req_tracker

---
 rtl/hpdcache_common_pkg.sv | 23 ++
 rtl/hpdcache_req_tracker_if.sv | 35 +++
 rtl/hpdcache_req_tracker_chan.sv | 97 +++++++++
 rtl/hpdcache_req_tracker.sv | 89 ++++++++
 4 files changed

// File: rtl/hpdcache_common_pkg.sv
// Shared definitions for the HPDcache request tracker: error-flag layout and helpers.
package hpdcache_common_pkg;

   localparam int unsigned ErrW = 4;

   // Bit positions inside the error vector {timeout, unexpected_rsp, dup_tid, unstable_req}
   localparam int unsigned ErrUnstable = 0;
   localparam int unsigned ErrDupTid   = 1;
   localparam int unsigned ErrUnexpRsp = 2;
   localparam int unsigned ErrTimeout  = 3;

   typedef logic [ErrW-1:0] hpdcache_err_t;

   function automatic logic [2:0] err_popcount(hpdcache_err_t e);
      logic [2:0] n;
      n = '0;
      for (int i = 0; i < int'(ErrW); i++) begin
         n = n + 3'(e[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/hpdcache_req_tracker_if.sv
// Core request/response channel bundle observed by the request tracker.
interface hpdcache_req_tracker_if #(
   parameter int unsigned NREQ  = 4,
   parameter int unsigned TID_W = 4
);

   logic [NREQ-1:0]            core_req_valid_i;
   logic [NREQ-1:0]            core_req_ready_i;
   logic [NREQ-1:0][TID_W-1:0] core_req_tid_i;
   logic [NREQ-1:0]            core_req_need_rsp_i;
   logic [NREQ-1:0]            core_req_abort_i;
   logic [NREQ-1:0]            core_rsp_valid_i;
   logic [NREQ-1:0][TID_W-1:0] core_rsp_tid_i;

   modport master (
      output core_req_valid_i,
      output core_req_ready_i,
      output core_req_tid_i,
      output core_req_need_rsp_i,
      output core_req_abort_i,
      output core_rsp_valid_i,
      output core_rsp_tid_i
   );

   modport slave (
      input core_req_valid_i,
      input core_req_ready_i,
      input core_req_tid_i,
      input core_req_need_rsp_i,
      input core_req_abort_i,
      input core_rsp_valid_i,
      input core_rsp_tid_i
   );

endinterface

// File: rtl/hpdcache_req_tracker_chan.sv
// Per-channel tracker: pending TID bitmap, request stability check and response watchdog.
module hpdcache_req_tracker_chan
   import hpdcache_common_pkg::*;
#(
   parameter int unsigned TID_W   = 4,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             req_valid_i,
   input  logic             req_ready_i,
   input  logic [TID_W-1:0] req_tid_i,
   input  logic             req_need_rsp_i,
   input  logic             req_abort_i,
   input  logic             rsp_valid_i,
   input  logic [TID_W-1:0] rsp_tid_i,
   output logic [TID_W:0]   outstanding_o,
   output hpdcache_err_t    err_evt_o
);

   localparam int unsigned NTid  = 2 ** TID_W;
   localparam int unsigned WdogW = $clog2(TIMEOUT + 1);
   localparam logic [WdogW-1:0] WdogMax = WdogW'(TIMEOUT);

   logic [NTid-1:0]    pending_q, pending_d;
   logic [TID_W:0]     outstanding_q, outstanding_d;
   logic               acc_q;
   logic [TID_W-1:0]   acc_tid_q;
   logic               stall_q;
   logic [TID_W-1:0]   stall_tid_q;
   logic               stall_need_q;
   logic [WdogW-1:0]   wdog_q, wdog_d;

   logic set_req, rsp_hit, unexp_rsp, dup_tid, unstable, timeout;

   always_comb begin
      set_req   = req_valid_i & req_ready_i & req_need_rsp_i;
      rsp_hit   = rsp_valid_i & pending_q[rsp_tid_i];
      unexp_rsp = rsp_valid_i & ~pending_q[rsp_tid_i];

      // Clears (response, abort) act on the pre-cycle state before the new request sets
      pending_d = pending_q;
      if (rsp_hit) pending_d[rsp_tid_i] = 1'b0;
      if (acc_q && req_abort_i) pending_d[acc_tid_q] = 1'b0;
      dup_tid = set_req & pending_d[req_tid_i];
      if (set_req) pending_d[req_tid_i] = 1'b1;

      outstanding_d = '0;
      for (int i = 0; i < int'(NTid); i++) begin
         outstanding_d = outstanding_d + (TID_W + 1)'(pending_d[i]);
      end

      unstable = stall_q & (~req_valid_i | (req_tid_i != stall_tid_q) |
                            (req_need_rsp_i != stall_need_q));

      timeout = 1'b0;
      if (rsp_valid_i || (outstanding_q == '0)) begin
         wdog_d = '0;
      end else if (wdog_q == WdogMax) begin
         wdog_d = wdog_q;
      end else begin
         wdog_d  = wdog_q + WdogW'(1);
         timeout = (wdog_d == WdogMax);
      end

      err_evt_o              = '0;
      err_evt_o[ErrTimeout]  = timeout;
      err_evt_o[ErrUnexpRsp] = unexp_rsp;
      err_evt_o[ErrDupTid]   = dup_tid;
      err_evt_o[ErrUnstable] = unstable;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pending_q     <= '0;
         outstanding_q <= '0;
         acc_q         <= 1'b0;
         acc_tid_q     <= '0;
         stall_q       <= 1'b0;
         stall_tid_q   <= '0;
         stall_need_q  <= 1'b0;
         wdog_q        <= '0;
      end else begin
         pending_q     <= pending_d;
         outstanding_q <= outstanding_d;
         acc_q         <= set_req;
         acc_tid_q     <= req_tid_i;
         stall_q       <= req_valid_i & ~req_ready_i;
         stall_tid_q   <= req_tid_i;
         stall_need_q  <= req_need_rsp_i;
         wdog_q        <= wdog_d;
      end
   end

   assign outstanding_o = outstanding_q;

endmodule

// File: rtl/hpdcache_req_tracker.sv
// Request tracker top: one tracker per core channel plus sticky error merging and counting.
module hpdcache_req_tracker
   import hpdcache_common_pkg::*;
#(
   parameter int unsigned NREQ    = 4,
   parameter int unsigned TID_W   = 4,
   parameter int unsigned TIMEOUT = 1024,
   parameter int unsigned CNT_W   = 16,
   localparam int unsigned ChanW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   hpdcache_req_tracker_if.slave      core,
   input  logic                       clr_i,
   output logic [NREQ-1:0][TID_W:0]   outstanding_o,
   output hpdcache_err_t              err_o,
   output logic [ChanW-1:0]           err_chan_o,
   output logic [CNT_W-1:0]           err_cnt_o
);

   localparam int unsigned EvtW = $clog2(ErrW * NREQ + 1);

   hpdcache_err_t    chan_evt [NREQ];
   hpdcache_err_t    err_q, err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [ChanW-1:0] chan_q, chan_d;
   logic             first_q, first_d;
   logic             first_base;
   logic [EvtW-1:0]  evt_total;
   logic [CNT_W:0]   cnt_sum;

   for (genvar c = 0; c < int'(NREQ); c++) begin : g_chan
      hpdcache_req_tracker_chan #(
         .TID_W   (TID_W),
         .TIMEOUT (TIMEOUT)
      ) u_chan (
         .clk_i          (clk_i),
         .rst_ni         (rst_ni),
         .req_valid_i    (core.core_req_valid_i[c]),
         .req_ready_i    (core.core_req_ready_i[c]),
         .req_tid_i      (core.core_req_tid_i[c]),
         .req_need_rsp_i (core.core_req_need_rsp_i[c]),
         .req_abort_i    (core.core_req_abort_i[c]),
         .rsp_valid_i    (core.core_rsp_valid_i[c]),
         .rsp_tid_i      (core.core_rsp_tid_i[c]),
         .outstanding_o  (outstanding_o[c]),
         .err_evt_o      (chan_evt[c])
      );
   end

   always_comb begin
      // A clear wipes the previous state first so that same-cycle events still land
      err_d      = clr_i ? '0 : err_q;
      chan_d     = clr_i ? '0 : chan_q;
      first_base = clr_i ? 1'b0 : first_q;
      first_d    = first_base;
      evt_total  = '0;
      // Walk downwards so the lowest channel with an event wins the first-error latch
      for (int c = int'(NREQ) - 1; c >= 0; c--) begin
         err_d     = err_d | chan_evt[c];
         evt_total = evt_total + EvtW'(err_popcount(chan_evt[c]));
         if (!first_base && (|chan_evt[c])) begin
            first_d = 1'b1;
            chan_d  = ChanW'(c);
         end
      end
      cnt_sum = {1'b0, (clr_i ? '0 : cnt_q)} + (CNT_W + 1)'(evt_total);
      cnt_d   = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         err_q   <= '0;
         cnt_q   <= '0;
         chan_q  <= '0;
         first_q <= 1'b0;
      end else begin
         err_q   <= err_d;
         cnt_q   <= cnt_d;
         chan_q  <= chan_d;
         first_q <= first_d;
      end
   end

   assign err_o      = err_q;
   assign err_cnt_o  = cnt_q;
   assign err_chan_o = chan_q;

endmodule
